// File: rtl/meta_sync_filter_if.sv
// ---------------------------------------------------------------------------
// meta_sync_filter_if
//   Groups the per-channel level inputs and the filtered level / edge outputs
//   of meta_sync_filter into one bundle.
//
//   iIn   [pWIDTH] : asynchronous level inputs (driven by the source side)
//   oOut  [pWIDTH] : synchronised, filtered levels
//   oRise [pWIDTH] : one-cycle pulse, channel's oOut went 0->1
//   oFall [pWIDTH] : one-cycle pulse, channel's oOut went 1->0
//   oChg           : OR of all oRise|oFall bits, aligned with them
//
//   master : the side that drives iIn and consumes the outputs
//   slave  : the synchroniser itself
// ---------------------------------------------------------------------------
interface meta_sync_filter_if #(
    parameter int unsigned pWIDTH = 8
);
    logic [pWIDTH-1:0] iIn;
    logic [pWIDTH-1:0] oOut;
    logic [pWIDTH-1:0] oRise;
    logic [pWIDTH-1:0] oFall;
    logic              oChg;

    modport master (
        output iIn,
        input  oOut,
        input  oRise,
        input  oFall,
        input  oChg
    );

    modport slave (
        input  iIn,
        output oOut,
        output oRise,
        output oFall,
        output oChg
    );
endinterface

// File: rtl/meta_sync_filter.sv
// ---------------------------------------------------------------------------
// meta_sync_filter
//   Multi-bit metastability synchroniser with a per-channel stability filter
//   and registered rise/fall pulses. Each channel is independent: its
//   asynchronous input passes through a pSTAGE flop chain, and the
//   synchronised value must then hold for pFILT consecutive cycles before
//   oOut accepts it. Excursions shorter than that are discarded and never
//   accumulate across glitches.
//
//   Parameters
//     pWIDTH  : number of channels (>=1)
//     pSTAGE  : synchroniser flops per channel (>=2)
//     pFILT   : cycles a new level must persist (>=1, 1 = no filtering)
//     pRSTVAL : per-channel reset value of the sync chain and oOut
//
//   Ports
//     iClk    : sole clock
//     iRst_n  : synchronous active-low reset
//     bus     : slave modport of meta_sync_filter_if
//               (iIn in; oOut, oRise, oFall, oChg out)
//
//   All outputs come straight from flops.
// ---------------------------------------------------------------------------
module meta_sync_filter #(
    parameter int unsigned       pWIDTH  = 8,
    parameter int unsigned       pSTAGE  = 3,
    parameter int unsigned       pFILT   = 4,
    parameter logic [pWIDTH-1:0] pRSTVAL = '0
) (
    input  logic              iClk,
    input  logic              iRst_n,
    meta_sync_filter_if.slave bus
);

    // Counter needs to reach pFILT-1; keep at least one bit for pFILT=1.
    localparam int unsigned     CW       = (pFILT > 1) ? $clog2(pFILT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(pFILT - 1);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    if (pWIDTH < 1) begin : g_bad_width
        $error("meta_sync_filter: pWIDTH must be >= 1");
    end
    if (pSTAGE < 2) begin : g_bad_stage
        $error("meta_sync_filter: pSTAGE must be >= 2");
    end
    if (pFILT < 1) begin : g_bad_filt
        $error("meta_sync_filter: pFILT must be >= 1");
    end

    // -----------------------------------------------------------------------
    // Synchroniser chain: stage 0 samples iIn, the last stage is the
    // synchronised value. Pure flop-to-flop shift, no logic in between.
    // -----------------------------------------------------------------------
    logic [pSTAGE-1:0][pWIDTH-1:0] sync_q;
    logic [pWIDTH-1:0]             sync_y;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            sync_q <= {pSTAGE{pRSTVAL}};
        end else begin
            sync_q <= {sync_q[pSTAGE-2:0], bus.iIn};
        end
    end

    assign sync_y = sync_q[pSTAGE-1];

    // -----------------------------------------------------------------------
    // Stability filter and edge pulses
    // -----------------------------------------------------------------------
    logic [pWIDTH-1:0][CW-1:0] cnt_q,  cnt_d;
    logic [pWIDTH-1:0]         out_q,  out_d;
    logic [pWIDTH-1:0]         rise_q, rise_d;
    logic [pWIDTH-1:0]         fall_q, fall_d;
    logic                      chg_q,  chg_d;

    always_comb begin
        cnt_d  = '0;
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int unsigned i = 0; i < pWIDTH; i++) begin
            if (sync_y[i] == out_q[i]) begin
                // Returning to the accepted level restarts the count.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                out_d[i]  = sync_y[i];
                rise_d[i] = sync_y[i];
                fall_d[i] = ~sync_y[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        // Derived from next-state pulses so oChg lands in the same cycle.
        chg_d = |(rise_d | fall_d);
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            cnt_q  <= '0;
            out_q  <= pRSTVAL;
            rise_q <= '0;
            fall_q <= '0;
            chg_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            chg_q  <= chg_d;
        end
    end

    assign bus.oOut  = out_q;
    assign bus.oRise = rise_q;
    assign bus.oFall = fall_q;
    assign bus.oChg  = chg_q;

endmodule
